pwm_sample_buffer: RTL
======================

Name: pwm_sample_buffer

Overview:
Prefetch FIFO between the SDRAM playback controller and the PWM generator. It keeps a small queue of 8-bit samples filled by issuing single-sample read requests upstream. It delivers one sample per PWM period on the generator's request pulse. On underrun it holds the last sample and counts the event, so a slow SDRAM refresh/read never glitches the PWM output.

Parameters:
DATA_W, 8, sample width in bits
DEPTH, 16, FIFO entries; power of two, >= 4
TIMEOUT, 255, max cycles to wait for upstream rd_valid before abandoning a request

Ports:
CLK  in  1  100 MHz system clock (same clock as the PWM counter)
reset  in  1  synchronous, active-high reset
en  in  1  playback enable (read mode); 0 = flush and idle
rd_req  out  1  one-cycle pulse requesting one sample from the controller
rd_valid  in  1  controller returns rd_data this cycle
rd_data  in  DATA_W  sample from SDRAM
sample_req  in  1  one-cycle pulse from the PWM generator at counter wrap
sample_out  out  DATA_W  current PWM compare value (registered)
sample_valid  out  1  1 once at least one real sample has been delivered since reset/flush
level  out  log2(DEPTH)+1  current FIFO occupancy
underrun  out  1  one-cycle pulse: sample_req while FIFO empty
underrun_cnt  out  8  saturating underrun counter
timeout_cnt  out  8  saturating abandoned-request counter

Behaviour:
- Reset (reset=1 at posedge CLK): all outputs 0, pointers 0, FSM = IDLE, FIFO empty. Reset takes effect on any cycle, including mid-request; a rd_valid arriving after reset is ignored unless the FSM is in WAIT.
- Refill FSM:
  - IDLE: if en and (level + 0) < DEPTH, go to REQ.
  - REQ: assert rd_req for exactly 1 cycle, clear the wait counter, go to WAIT.
  - WAIT: on rd_valid, push rd_data and go to IDLE. If the wait counter reaches TIMEOUT without rd_valid, go to IDLE and increment timeout_cnt (saturates at 255).
  - Only one request is outstanding at a time. rd_valid outside WAIT is ignored and not pushed.
- Pop: on sample_req with level>0, sample_out <= FIFO head one cycle later (registered), sample_valid <= 1, level decrements.
- Underrun: on sample_req with level==0, sample_out is unchanged, underrun pulses 1 cycle, underrun_cnt +1 (saturates at 255).
- Simultaneous push and pop:
  - level>0: both occur, level unchanged.
  - level==0: counts as an underrun; the pushed data enters the FIFO (no bypass) and level becomes 1.
- Full: a push is never issued when level==DEPTH (the FSM gates REQ). If rd_valid arrives in WAIT while full, which is only possible after a concurrent pop, the push still succeeds because the pop frees the slot in the same cycle.
- Pointers wrap modulo DEPTH; level is computed from pointer difference with an extra MSB so full and empty are distinguishable.
- en falling:
  - FIFO flushes (level=0) on the next cycle and the FSM returns to IDLE.
  - Any outstanding response is discarded.
  - sample_valid clears; sample_out holds its last value.
  - sample_req is ignored while en=0: no underrun is counted.
- Counters are cleared only by reset.
- Latency:
  - sample_req to sample_out update: 1 cycle.
  - Empty to first rd_req after en rises: 2 cycles.

Test Plan:
- Reset with en=1 and an immediate controller that answers rd_valid 3 cycles after rd_req with data 0x10,0x11,… → rd_req pulses, level rises to 16 and stops, no rd_req while level==16.
- Full FIFO, then sample_req every 256 cycles → sample_out = 0x10, 0x11, 0x12 in order, each 1 cycle after its req; a refill rd_req follows each pop.
- Controller stops responding, sample_req continues → FIFO drains to 0; the next sample_req gives an underrun pulse, sample_out holds the last value, underrun_cnt=1; 300 more reqs → underrun_cnt saturates at 255. A stuck WAIT gives timeout_cnt +1 after 255 cycles.
- level==0, sample_req and rd_valid(0xAB) in the same cycle → underrun=1, sample_out unchanged, level=1; the next sample_req gives sample_out=0xAB.
- en dropped while in WAIT with level=5 → next cycle level=0, sample_valid=0; a late rd_valid is not pushed; en raised again → rd_req within 2 cycles.
- reset asserted mid-WAIT with level=9 → all outputs 0 the next cycle, including the counters.

Source files
------------

// File: rtl/pwm_sample_buffer.sv
// Sample prefetch FIFO between the SDRAM playback controller and the PWM generator.
// Keeps a small queue topped up with single-sample reads and hands out one sample per PWM period.
module pwm_sample_buffer #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     en,
   output logic                     rd_req,
   input  logic                     rd_valid,
   input  logic [DATA_W-1:0]        rd_data,
   input  logic                     sample_req,
   output logic [DATA_W-1:0]        sample_out,
   output logic                     sample_valid,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     underrun,
   output logic [7:0]               underrun_cnt,
   output logic [7:0]               timeout_cnt
);

   localparam int AW  = $clog2(DEPTH);
   localparam int WCW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]    FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT
   } state_t;

   state_t              state, state_nx;
   logic [WCW-1:0]      wait_cnt, wait_cnt_nx;
   logic [AW:0]         wr_ptr, rd_ptr;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic                empty, full;
   logic                push, pop, ur_evt, to_evt;

   // Extra pointer MSB keeps full (DEPTH) and empty (0) apart.
   assign level = wr_ptr - rd_ptr;
   assign empty = (level == '0);
   assign full  = (level == FULL_LVL);

   // sample_req is ignored entirely while playback is disabled.
   assign pop    = en && sample_req && !empty;
   assign ur_evt = en && sample_req && empty;

   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push = en && (state == S_WAIT) && rd_valid && (!full || pop);

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      rd_req      = 1'b0;
      to_evt      = 1'b0;
      if (!en) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (!full) state_nx = S_REQ;
            end
            S_REQ: begin
               rd_req      = 1'b1;
               wait_cnt_nx = '0;
               state_nx    = S_WAIT;
            end
            S_WAIT: begin
               if (rd_valid) begin
                  state_nx = S_IDLE;
               end else if (wait_cnt == WAIT_LAST) begin
                  state_nx = S_IDLE;
                  to_evt   = 1'b1;
               end else begin
                  wait_cnt_nx = wait_cnt + 1'b1;
               end
            end
            default: state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   // Storage carries no reset; the pointers define what is valid.
   always_ff @(posedge CLK) begin
      if (!reset && push) mem[wr_ptr[AW-1:0]] <= rd_data;
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         sample_out   <= '0;
         sample_valid <= 1'b0;
      end else if (!en) begin
         // Flush by catching up the read side; sample_out keeps driving the PWM.
         rd_ptr       <= wr_ptr;
         sample_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr       <= rd_ptr + 1'b1;
            sample_out   <= mem[rd_ptr[AW-1:0]];
            sample_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
         timeout_cnt  <= '0;
      end else begin
         underrun <= ur_evt;
         if (ur_evt && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
         if (to_evt && timeout_cnt != 8'hFF)  timeout_cnt  <= timeout_cnt + 8'd1;
      end
   end

endmodule
